// File: rtl/decode_stage.sv
// RV32E single-entry decode stage: valid/ready fetch in, registered bundle out.
// Optional DECODE_ILLEGAL_TRAP_EN: transferring an ILLEGAL instruction also halts fetch.
module decode_stage (
  input  logic        clock,
  input  logic        nreset,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  input  logic        resume,
  output logic [3:0]  read_loc_1,
  output logic [3:0]  read_loc_2,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [3:0]  ex_op,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5,
  output logic [3:0]  ex_rd,
  output logic [3:0]  ex_rs1,
  output logic [3:0]  ex_rs2,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc,
  output logic        halted
);

  typedef enum logic [3:0] {
    OPC_ILLEGAL = 4'd0,
    OPC_LUI     = 4'd1,
    OPC_AUIPC   = 4'd2,
    OPC_JAL     = 4'd3,
    OPC_JALR    = 4'd4,
    OPC_BRANCH  = 4'd5,
    OPC_LOAD    = 4'd6,
    OPC_STORE   = 4'd7,
    OPC_OP_IMM  = 4'd8,
    OPC_OP      = 4'd9,
    OPC_FENCE   = 4'd10,
    OPC_SYSTEM  = 4'd11
  } op_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic        r_valid;
  op_t         r_op;
  logic [2:0]  r_funct3;
  logic        r_funct7b5;
  logic [3:0]  r_rd;
  logic [3:0]  r_rs1;
  logic [3:0]  r_rs2;
  logic [31:0] r_imm;
  logic [31:0] r_pc;

  logic [6:0]  w_opcode;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  op_t         w_op_raw;
  op_t         w_op;
  logic [31:0] w_imm;
  logic        w_use_rd;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_bad_reg;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs1;
  logic [3:0]  w_rs2;

  logic        w_transfer;
  logic        w_halt_req;
  logic        w_trap;

  assign w_opcode = fetch_instr[6:0];

  assign w_imm_i = {{20{fetch_instr[31]}}, fetch_instr[31:20]};
  assign w_imm_s = {{20{fetch_instr[31]}}, fetch_instr[31:25], fetch_instr[11:7]};
  assign w_imm_b = {{19{fetch_instr[31]}}, fetch_instr[31], fetch_instr[7],
                    fetch_instr[30:25], fetch_instr[11:8], 1'b0};
  assign w_imm_u = {fetch_instr[31:12], 12'b0};
  assign w_imm_j = {{11{fetch_instr[31]}}, fetch_instr[31], fetch_instr[19:12],
                    fetch_instr[20], fetch_instr[30:21], 1'b0};

  // FENCE and SYSTEM are decoded as I-type so their funct12/fm fields reach the executor.
  always_comb begin
    w_op_raw  = OPC_ILLEGAL;
    w_imm     = '0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      7'b0110111: begin w_op_raw = OPC_LUI;    w_imm = w_imm_u; w_use_rd = 1'b1; end
      7'b0010111: begin w_op_raw = OPC_AUIPC;  w_imm = w_imm_u; w_use_rd = 1'b1; end
      7'b1101111: begin w_op_raw = OPC_JAL;    w_imm = w_imm_j; w_use_rd = 1'b1; end
      7'b1100111: begin
        w_op_raw = OPC_JALR;   w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
      end
      7'b1100011: begin
        w_op_raw = OPC_BRANCH; w_imm = w_imm_b; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      7'b0000011: begin
        w_op_raw = OPC_LOAD;   w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
      end
      7'b0100011: begin
        w_op_raw = OPC_STORE;  w_imm = w_imm_s; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      7'b0010011: begin
        w_op_raw = OPC_OP_IMM; w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
      end
      7'b0110011: begin
        w_op_raw = OPC_OP; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      7'b0001111: begin
        w_op_raw = OPC_FENCE;  w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
      end
      7'b1110011: begin
        w_op_raw = OPC_SYSTEM; w_imm = w_imm_i; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
      end
      default: begin
        w_op_raw = OPC_ILLEGAL;
      end
    endcase
  end

  // Bit 4 of any used register field names x16..x31, which RV32E lacks.
  assign w_bad_reg = (w_use_rd  && fetch_instr[11]) ||
                     (w_use_rs1 && fetch_instr[19]) ||
                     (w_use_rs2 && fetch_instr[24]);

  assign w_op  = w_bad_reg ? OPC_ILLEGAL : w_op_raw;
  assign w_rd  = (w_use_rd  && !w_bad_reg) ? fetch_instr[10:7]  : '0;
  assign w_rs1 = (w_use_rs1 && !w_bad_reg) ? fetch_instr[18:15] : '0;
  assign w_rs2 = (w_use_rs2 && !w_bad_reg) ? fetch_instr[23:20] : '0;

  assign fetch_ready = (r_state == ST_RUN) && !flush && (!r_valid || ex_ready);
  assign w_transfer  = fetch_valid && fetch_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign w_trap = (w_op == OPC_ILLEGAL);
`else
  assign w_trap = 1'b0;
`endif

  assign w_halt_req = w_transfer &&
                      (((w_op == OPC_SYSTEM) && (fetch_instr[14:12] == 3'b000)) || w_trap);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (!flush && w_halt_req) w_state_next = ST_HALTED;
      end
      ST_HALTED: begin
        if (resume || flush) w_state_next = ST_RUN;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_valid <= 1'b0;
    end else if (w_transfer) begin
      r_valid <= 1'b1;
    end else if (flush || ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_op       <= OPC_ILLEGAL;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
    end else if (w_transfer) begin
      r_op       <= w_op;
      r_funct3   <= fetch_instr[14:12];
      r_funct7b5 <= fetch_instr[30];
      r_rd       <= w_rd;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_imm      <= w_imm;
      r_pc       <= fetch_pc;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_op       = r_op;
  assign ex_funct3   = r_funct3;
  assign ex_funct7b5 = r_funct7b5;
  assign ex_rd       = r_rd;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_imm      = r_imm;
  assign ex_pc       = r_pc;
  assign read_loc_1  = r_rs1;
  assign read_loc_2  = r_rs2;
  assign halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected bundles, a negedge monitor checks them.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        nreset;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        resume;
  logic [3:0]  read_loc_1;
  logic [3:0]  read_loc_2;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_op;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic [3:0]  ex_rd;
  logic [3:0]  ex_rs1;
  logic [3:0]  ex_rs2;
  logic [31:0] ex_imm;
  logic [31:0] ex_pc;
  logic        halted;

  decode_stage dut (
    .clock       (clock),
    .nreset      (nreset),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_instr (fetch_instr),
    .fetch_pc    (fetch_pc),
    .flush       (flush),
    .resume      (resume),
    .read_loc_1  (read_loc_1),
    .read_loc_2  (read_loc_2),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_op       (ex_op),
    .ex_funct3   (ex_funct3),
    .ex_funct7b5 (ex_funct7b5),
    .ex_rd       (ex_rd),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_imm      (ex_imm),
    .ex_pc       (ex_pc),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        chk_imm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic EXP_TRAP = 1'b1;
`else
  localparam logic EXP_TRAP = 1'b0;
`endif

  function automatic void chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(input logic [3:0] op, input logic [2:0] f3, input logic f7b5,
                              input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic [31:0] imm, input logic [31:0] pc, input logic ci);
    exp_t e;
    e.op = op; e.f3 = f3; e.f7b5 = f7b5; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.pc = pc; e.chk_imm = ci;
    return e;
  endfunction

  // Monitor: every cycle a bundle is presented it must match the head of the scoreboard.
  always @(negedge clock) begin
    if (nreset === 1'b1 && ex_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_bundle", {ex_op, ex_pc}, 96'h0);
      end else begin
        exp_t e;
        e = sb[0];
        chk("bundle",
            {ex_op, ex_funct3, ex_funct7b5, ex_rd, ex_rs1, ex_rs2,
             (e.chk_imm ? ex_imm : 32'h0), ex_pc},
            {e.op, e.f3, e.f7b5, e.rd, e.rs1, e.rs2,
             (e.chk_imm ? e.imm : 32'h0), e.pc});
        chk("read_loc", {read_loc_1, read_loc_2}, {e.rs1, e.rs2});
        if (ex_ready === 1'b1) void'(sb.pop_front());
      end
    end
  end

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input exp_t e,
                       output logic acc, output logic ev);
    fetch_valid = 1'b1;
    fetch_instr = instr;
    fetch_pc    = pc;
    @(negedge clock);
    acc = fetch_ready;
    ev  = ex_valid;
    @(posedge clock);
    #1;
    if (acc) sb.push_back(e);
  endtask

  task automatic idle();
    fetch_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc, ev;
    exp_t dummy;
    dummy = '0;
    nreset = 1'b1; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
    flush = 1'b0; resume = 1'b0; ex_ready = 1'b1;
    #1 nreset = 1'b0;
    #2;
    chk("reset_valid_halted", {ex_valid, halted}, 2'b00);
    chk("reset_fields", {ex_op, ex_funct3, ex_funct7b5, ex_rd, ex_rs1, ex_rs2, ex_imm, ex_pc}, '0);
    chk("reset_read_loc", {read_loc_1, read_loc_2}, 8'h00);
    chk("reset_fetch_ready", fetch_ready, 1'b1);
    repeat (2) @(posedge clock);
    @(negedge clock) nreset = 1'b1;
    @(posedge clock); #1;

    // addi x5,x0,7
    offer(32'h00700293, 32'h100, mk(4'd8, 3'd0, 1'b0, 4'd5, 4'd0, 4'd0, 32'd7, 32'h100, 1'b1), acc, ev);
    chk("addi_accept", acc, 1'b1);
    fetch_valid = 1'b0;
    @(negedge clock);
    chk("addi_valid", ex_valid, 1'b1);
    @(posedge clock); #1;
    idle();

    // lui x1,0x12345 held under backpressure
    ex_ready = 1'b0;
    offer(32'h123450B7, 32'h104, mk(4'd1, 3'd5, 1'b0, 4'd1, 4'd0, 4'd0, 32'h12345000, 32'h104, 1'b1), acc, ev);
    chk("lui_accept", acc, 1'b1);
    for (int k = 0; k < 3; k++) begin
      offer(32'h00700293, 32'h108, dummy, acc, ev);
      chk("stall_no_accept", acc, 1'b0);
      chk("stall_valid", ev, 1'b1);
    end
    fetch_valid = 1'b0;
    ex_ready = 1'b1;
    @(negedge clock);
    chk("release_fetch_ready", fetch_ready, 1'b1);
    @(posedge clock); #1;
    idle();

    // addi x16,x0,1: illegal in RV32E
    offer(32'h00100813, 32'h108, mk(4'd0, 3'd0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd0, 32'h108, 1'b0), acc, ev);
    chk("illegal_accept", acc, 1'b1);
    fetch_valid = 1'b0;
    @(negedge clock);
    chk("illegal_halted", halted, EXP_TRAP);
    @(posedge clock); #1;
    resume = 1'b1;
    idle();
    resume = 1'b0;
    idle();

    // ebreak halts fetch until resume
    offer(32'h00100073, 32'h10C, mk(4'd11, 3'd0, 1'b0, 4'd0, 4'd0, 4'd0, 32'd1, 32'h10C, 1'b1), acc, ev);
    chk("ebreak_accept", acc, 1'b1);
    chk("ebreak_halted", halted, 1'b1);
    offer(32'h00700293, 32'h110, dummy, acc, ev);
    chk("halted_no_accept", acc, 1'b0);
    resume = 1'b1;
    offer(32'h00700293, 32'h110, dummy, acc, ev);
    chk("resume_cycle_no_accept", acc, 1'b0);
    resume = 1'b0;
    chk("resumed_halted", halted, 1'b0);
    offer(32'h00700293, 32'h110, mk(4'd8, 3'd0, 1'b0, 4'd5, 4'd0, 4'd0, 32'd7, 32'h110, 1'b1), acc, ev);
    chk("after_resume_accept", acc, 1'b1);
    idle();
    idle();

    // flush while a bundle is held
    ex_ready = 1'b0;
    offer(32'h00300193, 32'h114, mk(4'd8, 3'd0, 1'b0, 4'd3, 4'd0, 4'd0, 32'd3, 32'h114, 1'b1), acc, ev);
    chk("pre_flush_accept", acc, 1'b1);
    flush = 1'b1;
    offer(32'h00700293, 32'h118, dummy, acc, ev);
    chk("flush_no_accept", acc, 1'b0);
    flush = 1'b0;
    fetch_valid = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clock);
    chk("flush_clears_valid", ex_valid, 1'b0);
    @(posedge clock); #1;
    ex_ready = 1'b1;
    idle();

    // back-to-back OP stream, then asynchronous reset mid-stream
    for (int i = 0; i < 8; i++) begin
      logic [3:0] rd, rs1, rs2;
      logic       f7;
      logic [31:0] ins;
      rd = 4'(i + 1); rs1 = 4'(i + 2); rs2 = 4'(i + 3); f7 = 1'(i % 2);
      ins = {1'b0, f7, 5'b0, 1'b0, rs2, 1'b0, rs1, 3'b000, 1'b0, rd, 7'b0110011};
      offer(ins, 32'h300 + 32'(4 * i), mk(4'd9, 3'd0, f7, rd, rs1, rs2, 32'd0, 32'h300 + 32'(4 * i), 1'b1),
            acc, ev);
      chk("stream_accept", acc, 1'b1);
      if (i > 0) chk("stream_no_bubble", ev, 1'b1);
    end
    #1 nreset = 1'b0;
    #1;
    chk("midreset_valid", ex_valid, 1'b0);
    chk("midreset_read_loc", {read_loc_1, read_loc_2}, 8'h00);
    chk("midreset_rd_pc", {ex_rd, ex_pc}, 36'h0);
    sb.delete();
    fetch_valid = 1'b0;
    @(negedge clock) nreset = 1'b1;
    @(posedge clock); #1;
    chk("post_reset_fetch_ready", fetch_ready, 1'b1);

    repeat (3) idle();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
